// File: rtl/count_pkg.sv
// Shared types and line levels for the counter's serial output stage.
// No logic, no latency.
// No flow control; constants only.
package count_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/baud_tick.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// bit_end is combinational from the count register (same cycle as count CLKS_PER_BIT-1).
// No backpressure; clear has priority over counting.
module baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [W-1:0] count;

    assign bit_end = (count == W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/count_uart_tx.sv
// UART transmitter for the counter value: start, 8 data LSB-first, optional even parity, stop.
// tx changes 1 cycle after the transfer edge; a frame takes N*CLKS_PER_BIT cycles plus one idle cycle.
// ready_out only in IDLE; valid_in while busy is dropped, never queued.
module count_uart_tx
    import count_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    state_t     state;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic       parity;
    logic       bit_end;

    assign ready_out = (state == IDLE);
    assign busy      = (state != IDLE);

    // Holding the timer clear in IDLE also covers the clear-on-transfer case.
    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= IDLE_LEVEL;
            shreg   <= '0;
            bit_idx <= '0;
            parity  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= IDLE_LEVEL;
                    if (valid_in) begin
                        shreg   <= data_in;
                        parity  <= ^data_in;
                        bit_idx <= '0;
                        tx      <= START_LEVEL;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx    <= shreg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    // tx always mirrors shreg[0]; the next bit is loaded as the register shifts.
                    if (bit_end) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            if (PARITY_EN) begin
                                tx    <= parity;
                                state <= PARITY;
                            end else begin
                                tx    <= STOP_LEVEL;
                                state <= STOP;
                            end
                        end else begin
                            tx      <= shreg[1];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx    <= STOP_LEVEL;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx    <= IDLE_LEVEL;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= IDLE_LEVEL;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx: three instances (C=4 no parity, C=4 parity, C=2 no parity)
// checked cycle by cycle against a frame model built from bit positions.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_count_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_w  [3];
    logic       valid_w [3];
    logic       rdy_w   [3];
    logic       tx_w    [3];
    logic       busy_w  [3];
    logic       done_w  [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    count_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_c4 (
        .clk(clk), .rst(rst), .data_in(data_w[0]), .valid_in(valid_w[0]),
        .ready_out(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    count_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_c4p (
        .clk(clk), .rst(rst), .data_in(data_w[1]), .valid_in(valid_w[1]),
        .ready_out(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    count_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0)) u_c2 (
        .clk(clk), .rst(rst), .data_in(data_w[2]), .valid_in(valid_w[2]),
        .ready_out(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    function automatic int cpb(input int id);
        return (id == 2) ? 2 : 4;
    endfunction

    function automatic int pen(input int id);
        return (id == 1) ? 1 : 0;
    endfunction

    function automatic int frame_len(input int id);
        return ((pen(id) != 0) ? 11 : 10) * cpb(id);
    endfunction

    // Expected line level t cycles after the transfer edge.
    function automatic logic exp_tx(input logic [7:0] d, input int id, input int t);
        int b;
        if (t < 1) return 1'b1;
        b = (t - 1) / cpb(id);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && pen(id) != 0) return ^d;
        return 1'b1;
    endfunction

    task automatic send(input int id, input logic [7:0] d);
        @(negedge clk);
        n_cmp++;
        if (rdy_w[id] !== 1'b1) begin
            n_err++;
            $display("FAIL send_ready id=%0d got=%b want=1", id, rdy_w[id]);
        end
        valid_w[id] = 1'b1;
        data_w[id]  = d;
        @(posedge clk);
    endtask

    // Watch a frame starting right after its transfer edge.
    // mode 0: drop valid; 1: keep valid high with data nxt; 2: random valid/data noise during frame.
    task automatic watch(input int id, input logic [7:0] d, input int mode,
                         input logic [7:0] nxt, input int tmax);
        int nf;
        int last;
        nf   = frame_len(id);
        last = (tmax > 0) ? tmax : nf + 1;
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            if (mode == 0 && t == 1) begin
                valid_w[id] = 1'b0;
                data_w[id]  = 8'($urandom);
            end else if (mode == 1 && t == 1) begin
                data_w[id] = nxt;
            end else if (mode == 2) begin
                valid_w[id] = (t < nf) ? 1'($urandom) : 1'b0;
                data_w[id]  = 8'($urandom);
            end
            n_cmp++;
            if (tx_w[id] !== exp_tx(d, id, t)) begin
                n_err++;
                $display("FAIL tx id=%0d data=%h t=%0d got=%b want=%b", id, d, t, tx_w[id], exp_tx(d, id, t));
            end
            n_cmp++;
            if (rdy_w[id] !== (t > nf)) begin
                n_err++;
                $display("FAIL ready id=%0d t=%0d got=%b want=%b", id, t, rdy_w[id], (t > nf));
            end
            n_cmp++;
            if (busy_w[id] !== (t <= nf)) begin
                n_err++;
                $display("FAIL busy id=%0d t=%0d got=%b want=%b", id, t, busy_w[id], (t <= nf));
            end
            n_cmp++;
            if (done_w[id] !== (t == nf + 1)) begin
                n_err++;
                $display("FAIL done id=%0d t=%0d got=%b want=%b", id, t, done_w[id], (t == nf + 1));
            end
        end
    endtask

    task automatic check_idle(input int id, input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({tx_w[id], rdy_w[id], busy_w[id], done_w[id]} !== 4'b1100) begin
                n_err++;
                $display("FAIL %s id=%0d cyc=%0d got tx/rdy/busy/done=%b%b%b%b want=1100",
                         tag, id, i, tx_w[id], rdy_w[id], busy_w[id], done_w[id]);
            end
        end
    endtask

    task automatic test_reset();
        for (int id = 0; id < 3; id++) begin
            valid_w[id] = 1'b0;
            data_w[id]  = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        fork
            check_idle(0, 20, "reset_idle");
            check_idle(1, 20, "reset_idle");
            check_idle(2, 20, "reset_idle");
        join
    endtask

    task automatic test_fixed_frames();
        send(0, 8'hA5);
        watch(0, 8'hA5, 0, 8'h00, 0);
        send(1, 8'h07);
        watch(1, 8'h07, 0, 8'h00, 0);
        send(1, 8'hA5);
        watch(1, 8'hA5, 0, 8'h00, 0);
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 9; i++) begin
            int id;
            logic [7:0] d;
            id = i % 3;
            d  = 8'($urandom);
            send(id, d);
            watch(id, d, 0, 8'h00, 0);
        end
    endtask

    task automatic test_back_to_back();
        send(2, 8'h00);
        watch(2, 8'h00, 1, 8'hFF, 0);
        @(posedge clk);
        watch(2, 8'hFF, 0, 8'h00, 0);
    endtask

    task automatic test_busy_ignore();
        logic [7:0] d;
        d = 8'($urandom);
        send(0, d);
        watch(0, d, 2, 8'h00, 0);
        check_idle(0, 12, "no_second_frame");
    endtask

    task automatic test_reset_midframe();
        send(0, 8'h96);
        watch(0, 8'h96, 0, 8'h00, 4 * cpb(0) + 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({tx_w[0], rdy_w[0], busy_w[0], done_w[0]} !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_abort got tx/rdy/busy/done=%b%b%b%b want=1100",
                     tx_w[0], rdy_w[0], busy_w[0], done_w[0]);
        end
        check_idle(0, 45, "after_abort");
        send(0, 8'h3C);
        watch(0, 8'h3C, 0, 8'h00, 0);
    endtask

    initial begin
        test_reset();
        test_fixed_frames();
        test_random_frames();
        test_back_to_back();
        test_busy_ignore();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
